// File: rtl/robertson_pkg.sv
// Shared types and defaults for the Robertson sequential multiplier.
package robertson_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/robertson_ctrl.sv
// Control FSM and bit counter for the Robertson multiplier: sequences load, WIDTH
// shift-add steps (last one subtracts) and a one-cycle done pulse.
module robertson_ctrl
    import robertson_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_i,
    output logic load_o,
    output logic step_o,
    output logic sub_sel_o,
    output logic ready_o,
    output logic busy_o,
    output logic done_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    count_d = '0;
                end
            end
            RUN: begin
                // Counter saturates on the last (sign-correction) iteration.
                if (count_q == LastCnt) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Handshake outputs decode the state register only.
    assign ready_o   = (state_q == IDLE);
    assign busy_o    = (state_q == RUN);
    assign done_o    = (state_q == DONE);
    assign load_o    = ready_o & start_i;
    assign step_o    = busy_o;
    assign sub_sel_o = (count_q == LastCnt);

endmodule

// File: rtl/robertson_mult_seq.sv
// Robertson shift-add two's-complement multiplier: A/Q/M datapath, one multiplier bit
// per clock, with the final multiplicand add replaced by a subtract for the sign bit.
module robertson_mult_seq
    import robertson_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic             load, step, sub_sel;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   ext_a, addend, sum;

    robertson_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_i   (start),
        .load_o    (load),
        .step_o    (step),
        .sub_sel_o (sub_sel),
        .ready_o   (ready),
        .busy_o    (busy),
        .done_o    (done)
    );

    always_comb begin
        ext_a  = {a_q[WIDTH-1], a_q};
        addend = q_q[0] ? {m_q[WIDTH-1], m_q} : '0;
        sum    = sub_sel ? (ext_a - addend) : (ext_a + addend);

        a_d = a_q;
        q_d = q_q;
        m_d = m_q;
        if (load) begin
            a_d = '0;
            q_d = multiplier;
            m_d = multiplicand;
        end else if (step) begin
            // Arithmetic right shift of the (WIDTH+1)-bit sum into {A,Q}.
            a_d = sum[WIDTH:1];
            q_d = {sum[0], q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            q_q <= '0;
            m_q <= '0;
        end else begin
            a_q <= a_d;
            q_q <= q_d;
            m_q <= m_d;
        end
    end

    assign product = {a_q, q_q};

endmodule

// File: tb/tb_robertson_mult_seq.sv
// Self-checking bench for robertson_mult_seq; expected products come from plain
// signed multiplication and handshake timing from the documented cycle counts.
module tb_robertson_mult_seq;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start;
    logic [W-1:0]   mcand, mplier;
    logic           ready, busy, done;
    logic [2*W-1:0] product;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    robertson_mult_seq #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[2*W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 30 && !ready; i++) tick();
    endtask

    // Launch one multiply; report product at done, edges from accept to done,
    // number of done pulses seen and ready one edge after done.
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb,
                            output logic [2*W-1:0] prod, output int lat, output int ndone,
                            output logic rdy);
        prod  = 'x;
        lat   = -1;
        ndone = 0;
        rdy   = 1'b0;
        wait_ready();
        if (!ready) return;
        mcand = a;
        mplier = b;
        start = 1'b1;
        tick();
        for (int i = 1; i <= W + 4; i++) begin
            if (disturb && i <= W + 1) begin
                mcand  = 8'($urandom);
                mplier = 8'($urandom);
                start  = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat  = i;
                    prod = product;
                end
            end
            if (i == W + 1) rdy = ready;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        mcand   = '0;
        mplier  = '0;
        #12;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (product !== 16'h0000) begin bad++; $display("FAIL reset_product: got %h want 0000", product); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [2*W-1:0] p; int lat, nd; logic rdy;
        run_mult(8'h03, 8'h05, 1'b0, p, lat, nd, rdy);
        total++; if (p !== 16'h000F) begin bad++; $display("FAIL basic_product: got %h want 000f", p); end
        total++; if (lat != W) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, W); end
        total++; if (nd != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", nd); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL basic_ready_return: got %b want 1", rdy); end
    endtask

    task automatic test_directed();
        logic [W-1:0]   da [8] = '{8'hFD, 8'h05, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h7F, 8'h07};
        logic [W-1:0]   db [8] = '{8'h05, 8'hFD, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h7F, 8'hFE};
        logic [2*W-1:0] de [8] = '{16'hFFF1, 16'hFFF1, 16'h0001, 16'h0000,
                                   16'h4000, 16'hC080, 16'h3F01, 16'hFFF2};
        logic [2*W-1:0] p; int lat, nd; logic rdy;
        for (int k = 0; k < 8; k++) begin
            run_mult(da[k], db[k], 1'b0, p, lat, nd, rdy);
            total++;
            if (p !== de[k] || nd != 1) begin
                bad++;
                $display("FAIL directed_%0d %h*%h: got %h (dones %0d) want %h (dones 1)",
                         k, da[k], db[k], p, nd, de[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b; logic [2*W-1:0] p, e; int lat, nd; logic rdy;
        for (int k = 0; k < 20; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            e = ref_mul(a, b);
            run_mult(a, b, 1'b0, p, lat, nd, rdy);
            total++;
            if (p !== e || lat != W) begin
                bad++;
                $display("FAIL random_%0d %h*%h: got %h lat %0d want %h lat %0d",
                         k, a, b, p, lat, e, W);
            end
        end
    endtask

    task automatic test_disturb();
        logic [W-1:0] a, b; logic [2*W-1:0] p, e; int lat, nd; logic rdy;
        for (int k = 0; k < 4; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            e = ref_mul(a, b);
            run_mult(a, b, 1'b1, p, lat, nd, rdy);
            total++;
            if (p !== e || nd != 1 || lat != W) begin
                bad++;
                $display("FAIL disturb_%0d %h*%h: got %h dones %0d lat %0d want %h dones 1 lat %0d",
                         k, a, b, p, nd, lat, e, W);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        int ndone = 0;
        int nbadp = 0;
        logic prev_ready;
        wait_ready();
        mcand  = 8'h02;
        mplier = 8'h02;
        start  = 1'b1;
        prev_ready = ready;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (prev_ready) acc_cyc.push_back(c);
            if (done) begin
                ndone++;
                if (product !== 16'h0004) nbadp++;
            end
            prev_ready = ready;
        end
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        // Accepts at edges 1, 11, 21, 31 (period WIDTH+2); each completes within 40 edges.
        total++; if (acc_cyc.size() != 4) begin bad++; $display("FAIL b2b_accepts: got %0d want 4", acc_cyc.size()); end
        total++; if (ndone != 4) begin bad++; $display("FAIL b2b_dones: got %0d want 4", ndone); end
        total++; if (nbadp != 0) begin bad++; $display("FAIL b2b_product: got %0d wrong want 0 wrong", nbadp); end
        for (int k = 1; k < acc_cyc.size(); k++) begin
            total++;
            if (acc_cyc[k] - acc_cyc[k-1] != W + 2) begin
                bad++;
                $display("FAIL b2b_spacing_%0d: got %0d want %0d", k, acc_cyc[k] - acc_cyc[k-1], W + 2);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [2*W-1:0] p; int lat, nd; logic rdy;
        int spurious = 0;
        wait_ready();
        mcand  = 8'h03;
        mplier = 8'h05;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrun_busy: got %b want 1", busy); end
        reset_n = 1'b0;
        #1;
        total++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            bad++;
            $display("FAIL midrun_abort: got r%b b%b d%b p%h want r1 b0 d0 p0000",
                     ready, busy, done, product);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) spurious++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            if (done) spurious++;
        end
        total++; if (spurious != 0) begin bad++; $display("FAIL midrun_no_done: got %0d pulses want 0", spurious); end
        run_mult(8'h07, 8'hFE, 1'b0, p, lat, nd, rdy);
        total++; if (p !== 16'hFFF2) begin bad++; $display("FAIL midrun_after: got %h want fff2", p); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_random();
        test_disturb();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
